// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR random source: maximal-length Galois tap masks
// and the mode encodings used by the game FSM.
package lfsr_pkg;

  // Right-shift Galois masks; the MSB is always set.
  localparam logic [3:0]  TAPS4  = 4'hC;
  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [23:0] TAPS24 = 24'hE1_0000;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;

  localparam logic MODE_PERIODIC  = 1'b0;
  localparam logic MODE_ON_DEMAND = 1'b1;

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register with seed loading and zero-seed substitution.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned          LFSR_W       = 32,
  parameter logic [LFSR_W-1:0]    TAPS         = LFSR_W'(TAPS32),
  parameter logic [LFSR_W-1:0]    SEED_DEFAULT = LFSR_W'(1),
  parameter int unsigned          OUT_W        = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [OUT_W-1:0]  sample_o
);

  if (LFSR_W < 2 || LFSR_W > 64) begin : g_bad_width
    $error("lfsr_core: LFSR_W out of range");
  end
  if (TAPS[LFSR_W-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_core: TAPS MSB must be set");
  end
  if (SEED_DEFAULT == '0) begin : g_bad_seed
    $error("lfsr_core: SEED_DEFAULT must be non-zero");
  end

  logic [LFSR_W-1:0] state_q, state_d;

  // Load wins over stepping; a zero seed would lock the register at zero.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? SEED_DEFAULT : seed_i;
    end else if (step_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEED_DEFAULT;
    end else begin
      state_q <= state_d;
    end
  end

  assign sample_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/lfsr_random_source.sv
// Pseudo-random source for the game logic: LFSR plus prescaler, sampled either
// periodically on the prescaler wrap or on request.
module lfsr_random_source
  import lfsr_pkg::*;
#(
  parameter int unsigned       LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(TAPS32),
  parameter int unsigned       RAND_W       = 4,
  parameter int unsigned       TICK_PERIOD  = 50_000_000,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              mode_i,
  input  logic              req_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [RAND_W-1:0] rand_o,
  output logic              rand_valid_o,
  output logic              tick_o
);

  if (RAND_W < 1 || RAND_W > LFSR_W) begin : g_bad_rand_w
    $error("lfsr_random_source: RAND_W out of range");
  end
  if (TICK_PERIOD < 2) begin : g_bad_period
    $error("lfsr_random_source: TICK_PERIOD must be >= 2");
  end

  localparam int unsigned  PrescW = $clog2(TICK_PERIOD);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_PERIOD - 1);

  logic [RAND_W-1:0] lfsr_low;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [RAND_W-1:0] rand_q, rand_d;
  logic              valid_q, valid_d;
  logic              tick_q, tick_d;
  logic              wrap, sample;

  lfsr_core #(
    .LFSR_W       (LFSR_W),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT),
    .OUT_W        (RAND_W)
  ) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .step_i   (enable_i),
    .load_i   (seed_load_i),
    .seed_i   (seed_i),
    .sample_o (lfsr_low)
  );

  assign wrap   = (presc_q == PrescLast);
  assign sample = enable_i & ((mode_i == MODE_ON_DEMAND) ? req_i : wrap);

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    valid_d = sample;
    rand_d  = sample ? lfsr_low : rand_q;
    if (seed_load_i) begin
      presc_d = '0;
    end else if (enable_i) begin
      presc_d = wrap ? '0 : presc_q + PrescW'(1);
      tick_d  = wrap;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      rand_q  <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
    end
  end

  assign rand_o       = rand_q;
  assign rand_valid_o = valid_q;
  assign tick_o       = tick_q;

endmodule
